// File: rtl/multi_mode_down_timer.sv
// Down-timer with one-shot/auto-reload modes, pause, abort and a saturating period counter.
// Optional retrigger-while-running behaviour is enabled by MULTI_MODE_DOWN_TIMER_RETRIG_EN.
module multi_mode_down_timer #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              auto_reload,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] periods
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              done_q, done_d;
  logic [PCNT_W-1:0] periods_q, periods_d;
  logic [PCNT_W-1:0] periods_inc;

  assign periods_inc = (periods_q == {PCNT_W{1'b1}}) ? periods_q : periods_q + PCNT_W'(1);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    periods_d = periods_q;

    if (abort) begin
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trig) begin
            if (load_val != '0) begin
              count_d   = load_val;
              periods_d = '0;
              state_d   = StRun;
            end else begin
              // Zero-length run completes immediately without leaving idle.
              done_d    = 1'b1;
              count_d   = '0;
              periods_d = PCNT_W'(1);
            end
          end
        end
        StRun: begin
`ifdef MULTI_MODE_DOWN_TIMER_RETRIG_EN
          if (trig) begin
            if (load_val != '0) begin
              count_d = load_val;
            end else begin
              done_d    = 1'b1;
              periods_d = periods_inc;
              count_d   = '0;
              state_d   = StIdle;
            end
          end else if (!pause) begin
`else
          if (!pause) begin
`endif
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              done_d    = 1'b1;
              periods_d = periods_inc;
              if (auto_reload && (load_val != '0)) begin
                count_d = load_val;
              end else begin
                count_d = '0;
                state_d = StIdle;
              end
            end else begin
              // Never decrement from zero; fall back to idle.
              count_d = '0;
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      done_q    <= 1'b0;
      periods_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      periods_q <= periods_d;
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == StRun);
  assign done    = done_q;
  assign periods = periods_q;

endmodule

// File: tb/tb_multi_mode_down_timer.sv
// Directed self-checking bench for multi_mode_down_timer (WIDTH=8, PCNT_W=8).
module tb_multi_mode_down_timer;

  logic       clk;
  logic       rst;
  logic       trig;
  logic [7:0] load_val;
  logic       auto_reload;
  logic       pause;
  logic       abort;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic [7:0] periods;

  int n_checks = 0;
  int n_fail   = 0;

  multi_mode_down_timer #(
    .WIDTH (8),
    .PCNT_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .periods    (periods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input int c, input int b, input int d, input int p);
    n_checks++;
    assert (count === 8'(c)) else begin
      n_fail++;
      $error("FAIL %s count: observed %0d expected %0d", tag, count, c);
    end
    n_checks++;
    assert (busy === 1'(b)) else begin
      n_fail++;
      $error("FAIL %s busy: observed %0d expected %0d", tag, busy, b);
    end
    n_checks++;
    assert (done === 1'(d)) else begin
      n_fail++;
      $error("FAIL %s done: observed %0d expected %0d", tag, done, d);
    end
    n_checks++;
    assert (periods === 8'(p)) else begin
      n_fail++;
      $error("FAIL %s periods: observed %0d expected %0d", tag, periods, p);
    end
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; load_val = 8'd0; auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    check("reset", 0, 0, 0, 0);

    // One-shot, L=5
    trig = 1'b1; load_val = 8'd5;
    step();
    trig = 1'b0; load_val = 8'd99;
    check("os_start", 5, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("os_dec", 5 - i, 1, 0, 0);
    end
    step();
    check("os_tc", 0, 0, 1, 1);
    step();
    check("os_after", 0, 0, 0, 1);

    // Auto-reload, L=3
    trig = 1'b1; load_val = 8'd3; auto_reload = 1'b1;
    step();
    trig = 1'b0;
    check("ar_start", 3, 1, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      step();
      check("ar_run", 3 - (i % 3), 1, (i % 3 == 0) ? 1 : 0, i / 3);
    end
    auto_reload = 1'b0;
    step();
    check("ar_stop2", 2, 1, 0, 3);
    step();
    check("ar_stop1", 1, 1, 0, 3);
    step();
    check("ar_stop_tc", 0, 0, 1, 4);

    // Pause, L=4
    trig = 1'b1; load_val = 8'd4;
    step();
    trig = 1'b0;
    check("pz_start", 4, 1, 0, 0);
    step();
    check("pz_3", 3, 1, 0, 0);
    step();
    check("pz_2", 2, 1, 0, 0);
    pause = 1'b1;
    step();
    check("pz_hold1", 2, 1, 0, 0);
    step();
    check("pz_hold2", 2, 1, 0, 0);
    pause = 1'b0;
    step();
    check("pz_1", 1, 1, 0, 0);
    step();
    check("pz_tc", 0, 0, 1, 1);

    // Abort with simultaneous trig, L=6
    trig = 1'b1; load_val = 8'd6;
    step();
    trig = 1'b0;
    check("ab_start", 6, 1, 0, 0);
    step();
    step();
    step();
    check("ab_at3", 3, 1, 0, 0);
    abort = 1'b1; trig = 1'b1;
    step();
    abort = 1'b0; trig = 1'b0;
    check("ab_abort", 0, 0, 0, 0);
    step();
    check("ab_idle", 0, 0, 0, 0);

    // Reset mid-run, then zero-length trig
    trig = 1'b1; load_val = 8'd5;
    step();
    trig = 1'b0;
    step();
    step();
    step();
    check("rs_at2", 2, 1, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs_mid", 0, 0, 0, 0);
    trig = 1'b1; load_val = 8'd0;
    step();
    trig = 1'b0;
    check("z_trig", 0, 0, 1, 1);
    step();
    check("z_after", 0, 0, 0, 1);

    // Period counter saturation with L=1 auto-reload
    trig = 1'b1; load_val = 8'd1; auto_reload = 1'b1;
    step();
    trig = 1'b0;
    check("sat_start", 1, 1, 0, 0);
    for (int i = 1; i <= 255; i++) step();
    check("sat_255", 1, 1, 1, 255);
    for (int i = 0; i < 20; i++) step();
    check("sat_hold", 1, 1, 1, 255);
    abort = 1'b1;
    step();
    abort = 1'b0; auto_reload = 1'b0;
    check("sat_abort", 0, 0, 0, 255);

    // Retrigger in RUN
    trig = 1'b1; load_val = 8'd5;
    step();
    trig = 1'b0;
    check("rt_start", 5, 1, 0, 0);
    step();
    step();
    step();
    check("rt_at2", 2, 1, 0, 0);
    trig = 1'b1; load_val = 8'd7;
    step();
    trig = 1'b0;
`ifdef MULTI_MODE_DOWN_TIMER_RETRIG_EN
    check("rt_reload", 7, 1, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check("rt_dec", 7 - i, 1, 0, 0);
    end
    step();
    check("rt_tc", 0, 0, 1, 1);
`else
    check("rt_ignored", 1, 1, 0, 0);
    step();
    check("rt_tc", 0, 0, 1, 1);
`endif
    step();
    check("rt_after", 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
